// File: rtl/frame_sequencer.sv
// APU frame counter: divides the CPU clock into frame steps and issues quarter/half-frame
// strobes plus the 4-step-mode frame IRQ.
module frame_sequencer #(
    parameter int unsigned STEP_PERIOD = 7457
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] reg_4017,
    input  logic       reg_event,
    input  logic       status_read,
    output logic       enable_240hz,
    output logic       enable_120hz,
    output logic       frame_irq,
    output logic [2:0] frame_step
);

    localparam logic [14:0] LastCount = 15'(STEP_PERIOD - 1);

    typedef enum logic [2:0] {
        Step0 = 3'd0,
        Step1 = 3'd1,
        Step2 = 3'd2,
        Step3 = 3'd3,
        Step4 = 3'd4
    } step_e;

    step_e       step_q, step_d;
    logic [14:0] div_q, div_d;
    logic        mode_q, mode_d;
    logic        inhibit_q, inhibit_d;
    logic        quarter_q, quarter_d;
    logic        half_q, half_d;
    logic        irq_q, irq_d;
    logic        irq_pend_q, irq_pend_d;

    logic boundary;
    logic step_quarter, step_half, step_irq;

    logic unused_reg_bits;
    assign unused_reg_bits = ^reg_4017[5:0];

    assign boundary = (div_q == LastCount);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= Step0;
        end else begin
            step_q <= step_d;
        end
    end

    // Next-state: a register write restarts the frame and overrides a coincident boundary
    always_comb begin
        step_d = step_q;
        if (reg_event) begin
            step_d = Step0;
        end else if (boundary) begin
            unique case (step_q)
                Step0:   step_d = Step1;
                Step1:   step_d = Step2;
                Step2:   step_d = Step3;
                Step3:   step_d = mode_q ? Step4 : Step0;
                Step4:   step_d = Step0;
                default: step_d = Step0;
            endcase
        end
    end

    // Output decode for the step being processed at a boundary
    always_comb begin
        step_quarter = 1'b0;
        step_half    = 1'b0;
        step_irq     = 1'b0;
        unique case (step_q)
            Step0, Step2: step_quarter = 1'b1;
            Step1: begin
                step_quarter = 1'b1;
                step_half    = 1'b1;
            end
            Step3: begin
                step_quarter = !mode_q;
                step_half    = !mode_q;
                step_irq     = !mode_q;
            end
            Step4: begin
                step_quarter = 1'b1;
                step_half    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        div_d      = (reg_event || boundary) ? 15'd0 : div_q + 15'd1;
        mode_d     = reg_event ? reg_4017[7] : mode_q;
        inhibit_d  = reg_event ? reg_4017[6] : inhibit_q;
        quarter_d  = reg_event ? reg_4017[7] : (boundary && step_quarter);
        half_d     = reg_event ? reg_4017[7] : (boundary && step_half);
        irq_pend_d = !reg_event && boundary && step_irq && !inhibit_q;
        // The IRQ lands one cycle after the step-3 strobe; a pending set beats a status read
        if (reg_event && reg_4017[6]) begin
            irq_d = 1'b0;
        end else if (irq_pend_q) begin
            irq_d = 1'b1;
        end else if (status_read) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= 15'd0;
            mode_q     <= 1'b0;
            inhibit_q  <= 1'b0;
            quarter_q  <= 1'b0;
            half_q     <= 1'b0;
            irq_q      <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            mode_q     <= mode_d;
            inhibit_q  <= inhibit_d;
            quarter_q  <= quarter_d;
            half_q     <= half_d;
            irq_q      <= irq_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign enable_240hz = quarter_q;
    assign enable_120hz = half_q;
    assign frame_irq    = irq_q;
    assign frame_step   = step_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: expected strobes are queued by the stimulus and
// popped by a monitor; a second default-period instance checks long-run timing.
module tb_frame_sequencer;

    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst, reg_event, status_read;
    logic [7:0] reg_4017;
    logic       q, h, irq;
    logic [2:0] step;
    logic       rst2, sr2;
    logic       q2, h2, irq2;
    logic [2:0] step2;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    logic done2 = 1'b0;

    typedef struct {
        int         t;
        logic       half;
        logic [2:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_sequencer #(.STEP_PERIOD(P)) dut (
        .clk(clk), .rst(rst), .reg_4017(reg_4017), .reg_event(reg_event),
        .status_read(status_read), .enable_240hz(q), .enable_120hz(h),
        .frame_irq(irq), .frame_step(step)
    );

    frame_sequencer dut2 (
        .clk(clk), .rst(rst2), .reg_4017(8'h00), .reg_event(1'b0),
        .status_read(sr2), .enable_240hz(q2), .enable_120hz(h2),
        .frame_irq(irq2), .frame_step(step2)
    );

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic push(input int t, input logic half, input int st);
        exp_t e;
        e.t = t;
        e.half = half;
        e.st = 3'(st);
        sb.push_back(e);
    endtask

    task automatic push_frames(input int w, input bit mode5, input int kmax);
        int n;
        int sbef;
        n = mode5 ? 5 : 4;
        for (int k = 1; k <= kmax; k++) begin
            sbef = (k - 1) % n;
            if (!(mode5 && sbef == 3)) begin
                push(w + P * k, (sbef == 1) || (sbef == 3 && !mode5) || (sbef == 4), k % n);
            end
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic write(input logic [7:0] v, output int w);
        reg_4017 = v;
        reg_event = 1'b1;
        @(negedge clk);
        reg_event = 1'b0;
        w = cyc;
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (q || h) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", cyc, -1);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_time", cyc, mon_e.t);
                check("strobe_half", int'(h), int'(mon_e.half));
                check("strobe_step", int'(step), int'(mon_e.st));
            end
            if (h) check("half_implies_quarter", int'(q), 1);
        end
    end

    // Default-period instance: strobe period and IRQ period with status reads
    initial begin
        int base2, last_q, nq, last_irq, nirq;
        rst2 = 1'b1;
        sr2 = 1'b0;
        last_q = -1;
        nq = 0;
        last_irq = -1;
        nirq = 0;
        @(negedge clk);
        rst2 = 1'b0;
        base2 = cyc;
        while (nirq < 2 && cyc < 62000) begin
            @(negedge clk);
            sr2 = 1'b0;
            if (q2) begin
                if (last_q >= 0 && nq < 6) begin
                    check("period_240hz", cyc - last_q, 7457);
                    nq++;
                end
                last_q = cyc;
            end
            if (irq2) begin
                if (last_irq < 0) check("irq_first", cyc - base2, 4 * 7457 + 1);
                else check("irq_period", cyc - last_irq, 29828);
                last_irq = cyc;
                nirq++;
                sr2 = 1'b1;
            end
        end
        if (nirq < 2) check("dut2_irq_count", nirq, 2);
        done2 = 1'b1;
    end

    initial begin
        int base, w, w2, w3, w4;
        rst = 1'b1;
        reg_event = 1'b0;
        status_read = 1'b0;
        reg_4017 = 8'h00;
        @(negedge clk);
        check("reset_quarter", int'(q), 0);
        check("reset_step", int'(step), 0);
        check("reset_irq", int'(irq), 0);
        rst = 1'b0;
        base = cyc;

        // Test 1: free-running 4-step frame; status read coincident with IRQ set loses
        push_frames(base, 1'b0, 5);
        wait_to(base + 32);
        check("irq_before_set", int'(irq), 0);
        status_read = 1'b1;
        @(negedge clk);
        status_read = 1'b0;
        check("irq_set_wins", int'(irq), 1);
        wait_to(base + 40);
        check("irq_held", int'(irq), 1);

        // Test 3: status read clears; inhibit write keeps IRQ off
        status_read = 1'b1;
        @(negedge clk);
        status_read = 1'b0;
        check("irq_cleared_by_read", int'(irq), 0);
        write(8'h40, w);
        push_frames(w, 1'b0, 12);
        for (int i = 1; i <= 10; i++) begin
            wait_to(w + 10 * i);
            check("irq_inhibited", int'(irq), 0);
        end

        // Test 2: 5-step mode with immediate strobe
        write(8'h80, w2);
        push(w2, 1'b1, 0);
        push_frames(w2, 1'b1, 5);
        check("mode5_immediate_quarter", int'(q), 1);
        check("mode5_immediate_half", int'(h), 1);
        wait_to(w2 + 40);
        check("mode5_no_irq", int'(irq), 0);

        // Test 4: write landing on the boundary cycle suppresses the step strobe
        write(8'h00, w3);
        push_frames(w3, 1'b0, 1);
        wait_to(w3 + 15);
        write(8'h00, w4);
        check("boundary_write_step", int'(step), 0);
        check("boundary_write_no_strobe", int'(q), 0);
        push_frames(w4, 1'b0, 2);

        // Test 5: reset mid-frame at divider 5, step 2
        wait_to(w4 + 21);
        check("pre_reset_step", int'(step), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_step", int'(step), 0);
        check("midreset_quarter", int'(q), 0);
        check("midreset_half", int'(h), 0);
        check("midreset_irq", int'(irq), 0);
        base = cyc;
        push(base + P, 1'b0, 1);
        wait_to(base + P + 2);
        rst = 1'b1;

        while (!done2 && cyc < 70000) @(negedge clk);
        if (!done2) check("dut2_timeout", 0, 1);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
